// File: rtl/line_refill_controller_pkg.sv
// line_refill_controller_pkg: shared state encoding, log2 helper and default-derived widths
package line_refill_controller_pkg;
  function automatic int log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  localparam int NUMBER_OF_WAYS_DEF = 8;
  localparam int INDEX_BITS_DEF = 8;
  localparam int TAG_BITS_DEF = 20;
  localparam int WORDS_PER_LINE_DEF = 4;
  localparam int WAY_BITS = log2(NUMBER_OF_WAYS_DEF);
  localparam int WORD_BITS = log2(WORDS_PER_LINE_DEF);
  localparam int MEM_ADDR_BITS = TAG_BITS_DEF + INDEX_BITS_DEF + WORD_BITS;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_WB_RD,
    S_WB_WR,
    S_FILL,
    S_COMMIT,
    S_DONE
  } state_e;
endpackage

// File: rtl/line_refill_controller_onehot_to_binary.sv
// onehot_to_binary: lowest-set-bit encoder; all-zero input encodes to 0
module onehot_to_binary
  import line_refill_controller_pkg::*;
#(
  parameter int NUMBER_OF_WAYS = NUMBER_OF_WAYS_DEF,
  localparam int WAY_W = log2(NUMBER_OF_WAYS)
) (
  input  logic [NUMBER_OF_WAYS-1:0] onehot_i,
  output logic [WAY_W-1:0]          bin_o
);
  always_comb begin
    bin_o = '0;
    for (int i = NUMBER_OF_WAYS - 1; i >= 0; i--) if (onehot_i[i]) bin_o = i[WAY_W-1:0];
  end
endmodule

// File: rtl/line_refill_controller.sv
// line_refill_controller: miss handler that writes back a dirty victim, refills the line
// word-by-word from memory, commits the tag and reports the filled way to the LRU tracker
module line_refill_controller
  import line_refill_controller_pkg::*;
#(
  parameter int NUMBER_OF_WAYS = NUMBER_OF_WAYS_DEF,
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int TAG_BITS = TAG_BITS_DEF,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter int DATA_WIDTH = 32,
  localparam int WAY_W = log2(NUMBER_OF_WAYS),
  localparam int WORD_W = log2(WORDS_PER_LINE),
  localparam int ADDR_W = TAG_BITS + INDEX_BITS + WORD_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      miss_req_i,
  input  logic [INDEX_BITS-1:0]     miss_index_i,
  input  logic [TAG_BITS-1:0]       miss_tag_i,
  output logic                      miss_ack_o,
  input  logic [NUMBER_OF_WAYS-1:0] selected_way_i,
  input  logic                      victim_valid_i,
  input  logic                      victim_dirty_i,
  input  logic [TAG_BITS-1:0]       victim_tag_i,
  output logic [WAY_W-1:0]          array_way_o,
  output logic [INDEX_BITS-1:0]     array_index_o,
  output logic [WORD_W-1:0]         array_word_o,
  input  logic [DATA_WIDTH-1:0]     array_rd_data_i,
  output logic                      array_we_o,
  output logic [DATA_WIDTH-1:0]     array_wr_data_o,
  output logic                      array_tag_we_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wr_data_o,
  input  logic                      mem_ready_i,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data_i,
  output logic [WAY_W-1:0]          lru_access_o,
  output logic                      lru_access_valid_o
);
  state_e                    state_q, state_d;
  logic [WORD_W-1:0]         cnt_q, cnt_d;
  logic [INDEX_BITS-1:0]     idx_q;
  logic [TAG_BITS-1:0]       tag_q, vtag_q;
  logic [NUMBER_OF_WAYS-1:0] sel_q;
  logic [DATA_WIDTH-1:0]     rd_q;
  logic                      fresh_q;
  logic [WAY_W-1:0]          way;
  logic                      busy, last, wb_wr, fill;
  onehot_to_binary #(.NUMBER_OF_WAYS(NUMBER_OF_WAYS)) u_enc (
    .onehot_i(sel_q),
    .bin_o   (way)
  );
  assign busy = state_q != S_IDLE;
  assign last = cnt_q == WORD_W'(WORDS_PER_LINE - 1);
  assign wb_wr = state_q == S_WB_WR;
  assign fill = state_q == S_FILL;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE:   state_d = miss_req_i ? S_SELECT : S_IDLE;
      S_SELECT: state_d = (victim_valid_i && victim_dirty_i) ? S_WB_RD : S_FILL;
      S_WB_RD:  state_d = S_WB_WR;
      S_WB_WR: if (mem_ready_i) begin
        state_d = last ? S_FILL : S_WB_RD;
        cnt_d = last ? '0 : cnt_q + 1'b1;
      end
      S_FILL: if (mem_ready_i) begin
        state_d = last ? S_COMMIT : S_FILL;
        cnt_d = last ? '0 : cnt_q + 1'b1;
      end
      S_COMMIT: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end
  // The array word arrives in the first WB_WR cycle; hold a copy for the rest of any stall
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      tag_q <= '0;
      sel_q <= '0;
      vtag_q <= '0;
      rd_q <= '0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fresh_q <= state_q == S_WB_RD;
      if (state_q == S_IDLE && miss_req_i) begin
        idx_q <= miss_index_i;
        tag_q <= miss_tag_i;
        sel_q <= selected_way_i;
      end
      if (state_q == S_SELECT) vtag_q <= victim_tag_i;
      if (fresh_q) rd_q <= array_rd_data_i;
    end
  end
  assign array_way_o = busy ? way : '0;
  assign array_index_o = busy ? idx_q : '0;
  assign array_word_o = busy ? cnt_q : '0;
  assign array_we_o = fill && mem_ready_i;
  assign array_wr_data_o = fill ? mem_rd_data_i : '0;
  assign array_tag_we_o = state_q == S_COMMIT;
  assign mem_req_o = wb_wr || fill;
  assign mem_we_o = wb_wr;
  assign mem_addr_o = wb_wr ? {vtag_q, idx_q, cnt_q} : fill ? {tag_q, idx_q, cnt_q} : '0;
  assign mem_wr_data_o = wb_wr ? (fresh_q ? array_rd_data_i : rd_q) : '0;
  assign lru_access_o = (state_q == S_COMMIT) ? way : '0;
  assign lru_access_valid_o = state_q == S_COMMIT;
  assign miss_ack_o = state_q == S_DONE;
endmodule
